// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   owner_t     : which requester owns / is granted the memory port.
//   arb_state_t : arbiter FSM state (IDLE = port free, BUSY = one
//                 transaction outstanding, waiting for its response).
package mem_arb_pkg;

    typedef enum logic {
        IMEM = 1'b0,
        DMEM = 1'b1
    } owner_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the memory port arbiter: the fetch request/response
// channel (imem_*), the load/store channel (dmem_*) and the shared memory
// channel (mem_*).
//
// Handshake rule for every channel: a transfer happens on a rising clock
// edge where valid and ready are both high. A source holds valid and its
// payload stable until that edge; ready may depend combinationally on valid.
//
// Modports:
//   slave  : the arbiter side (takes requester requests, drives memory).
//   master : the environment side (requesters + memory model).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  imem_req_valid;
    logic [ADDR_W-1:0]     imem_req_addr;
    logic                  imem_req_ready;
    logic                  imem_resp_valid;
    logic [DATA_W-1:0]     imem_resp_data;
    logic                  imem_resp_ready;

    logic                  dmem_req_valid;
    logic [ADDR_W-1:0]     dmem_req_addr;
    logic                  dmem_req_we;
    logic [DATA_W-1:0]     dmem_req_wdata;
    logic [DATA_W/8-1:0]   dmem_req_wstrb;
    logic                  dmem_req_ready;
    logic                  dmem_resp_valid;
    logic [DATA_W-1:0]     dmem_resp_data;
    logic                  dmem_resp_ready;

    logic                  mem_req_valid;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic                  mem_req_we;
    logic [DATA_W-1:0]     mem_req_wdata;
    logic [DATA_W/8-1:0]   mem_req_wstrb;
    logic                  mem_req_ready;
    logic                  mem_resp_valid;
    logic [DATA_W-1:0]     mem_resp_data;
    logic                  mem_resp_ready;

    modport slave (
        input  imem_req_valid, imem_req_addr, imem_resp_ready,
        input  dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wdata,
        input  dmem_req_wstrb, dmem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_data,
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
        output mem_req_wstrb, mem_resp_ready
    );

    modport master (
        output imem_req_valid, imem_req_addr, imem_resp_ready,
        output dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wdata,
        output dmem_req_wstrb, dmem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
        input  mem_req_wstrb, mem_resp_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with lock. Purely combinational.
// Ports:
//   req[1:0]   in  : req[0] = IMEM valid, req[1] = DMEM valid.
//   last_grant in  : requester granted on the previous fired request.
//   lock_valid in  : a stalled grant is pinned.
//   lock_owner in  : the pinned requester.
//   grant      out : selected requester (IMEM when nothing is requesting).
//   any        out : at least one requester is valid.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_grant,
    input  logic       lock_valid,
    input  owner_t     lock_owner,
    output owner_t     grant,
    output logic       any
);

    always_comb begin
        any   = |req;
        grant = IMEM;
        if (lock_valid) begin
            // A request already presented to a stalled memory must not change.
            grant = lock_owner;
        end else if (req == 2'b11) begin
            grant = (last_grant == IMEM) ? DMEM : IMEM;
        end else if (req[1]) begin
            grant = DMEM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (imem) and load/store
// (dmem). At most one transaction is outstanding; its response is routed
// back to the requester that issued it.
// Ports:
//   clk, reset    : rising-edge clock, synchronous active-high reset.
//   bus           : imem/dmem/mem channels (see mem_port_arbiter_if).
//   spurious_resp : one-cycle pulse when a memory response arrives in IDLE.
//   state_dbg     : current FSM state, for observation only.
// All outputs are combinational from registered state plus inputs; the
// request mux does not depend on mem_resp_*.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                spurious_resp,
    output arb_state_t          state_dbg
);

    arb_state_t state, state_n;
    owner_t     owner, owner_n;
    owner_t     last_grant, last_grant_n;
    logic       lock_valid, lock_valid_n;
    owner_t     lock_owner, lock_owner_n;

    owner_t     grant;
    logic       any;

    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W/8-1:0] req_wstrb;
    logic                req_we;

    rr_arb2 u_rr_arb2 (
        .req        ({bus.dmem_req_valid, bus.imem_req_valid}),
        .last_grant (last_grant),
        .lock_valid (lock_valid),
        .lock_owner (lock_owner),
        .grant      (grant),
        .any        (any)
    );

    // Payload of the granted requester; fetch requests are always reads.
    always_comb begin
        req_addr  = bus.imem_req_addr;
        req_we    = 1'b0;
        req_wdata = '0;
        req_wstrb = '0;
        if (grant == DMEM) begin
            req_addr  = bus.dmem_req_addr;
            req_we    = bus.dmem_req_we;
            req_wdata = bus.dmem_req_wdata;
            req_wstrb = bus.dmem_req_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= IMEM;
            last_grant <= DMEM;   // IMEM wins the first tie
            lock_valid <= 1'b0;
            lock_owner <= IMEM;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            lock_valid <= lock_valid_n;
            lock_owner <= lock_owner_n;
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        lock_valid_n = lock_valid;
        lock_owner_n = lock_owner;

        bus.mem_req_valid   = 1'b0;
        bus.mem_req_addr    = '0;
        bus.mem_req_we      = 1'b0;
        bus.mem_req_wdata   = '0;
        bus.mem_req_wstrb   = '0;
        bus.mem_resp_ready  = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.dmem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.dmem_resp_valid = 1'b0;
        bus.dmem_resp_data  = '0;
        spurious_resp       = 1'b0;

        case (state)
            IDLE: begin
                bus.mem_req_valid = any;
                bus.mem_req_addr  = req_addr;
                bus.mem_req_we    = req_we;
                bus.mem_req_wdata = req_wdata;
                bus.mem_req_wstrb = req_wstrb;
                if (grant == IMEM) begin
                    bus.imem_req_ready = bus.mem_req_ready;
                end else begin
                    bus.dmem_req_ready = bus.mem_req_ready;
                end
                // Stray responses (e.g. from a transaction cut off by reset)
                // are drained here and flagged, never forwarded.
                bus.mem_resp_ready = 1'b1;
                spurious_resp      = bus.mem_resp_valid;
                if (any && bus.mem_req_ready) begin
                    state_n      = BUSY;
                    owner_n      = grant;
                    last_grant_n = grant;
                    lock_valid_n = 1'b0;
                end else if (any) begin
                    lock_valid_n = 1'b1;
                    lock_owner_n = grant;
                end
            end
            BUSY: begin
                if (owner == IMEM) begin
                    bus.imem_resp_valid = bus.mem_resp_valid;
                    bus.imem_resp_data  = bus.mem_resp_data;
                    bus.mem_resp_ready  = bus.imem_resp_ready;
                end else begin
                    bus.dmem_resp_valid = bus.mem_resp_valid;
                    bus.dmem_resp_data  = bus.mem_resp_data;
                    bus.mem_resp_ready  = bus.dmem_resp_ready;
                end
                if (bus.mem_resp_valid && bus.mem_resp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single memory port between the instruction fetch requester and the data (load/store) requester. Runs valid/ready handshakes on both sides, keeps at most one transaction outstanding, and routes each response back to the requester that issued it. Sits between the fetch/LSU stages and the memory model/bus, in front of the memory side of the fetch stage's request/response interface.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; `DATA_W/8` strobe bits.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req_valid`  in  1  fetch request valid.
- `imem_req_addr`  in  ADDR_W  fetch address.
- `imem_req_ready`  out  1  fetch request accepted.
- `imem_resp_valid`  out  1  fetch response valid.
- `imem_resp_data`  out  DATA_W  fetch read data.
- `imem_resp_ready`  in  1  fetch can take the response.
- `dmem_req_valid`  in  1  data request valid.
- `dmem_req_addr`  in  ADDR_W  data address.
- `dmem_req_we`  in  1  1 = write, 0 = read.
- `dmem_req_wdata`  in  DATA_W  write data.
- `dmem_req_wstrb`  in  DATA_W/8  byte enables.
- `dmem_req_ready`  out  1  data request accepted.
- `dmem_resp_valid`  out  1  data response valid (reads and write acks).
- `dmem_resp_data`  out  DATA_W  read data; don't-care for writes.
- `dmem_resp_ready`  in  1  LSU can take the response.
- `mem_req_valid`, `mem_req_addr`, `mem_req_we`, `mem_req_wdata`, `mem_req_wstrb`  out  1/ADDR_W/1/DATA_W/DATA_W/8  shared memory request.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_resp_valid`  in  1  memory response valid.
- `mem_resp_data`  in  DATA_W  memory read data.
- `mem_resp_ready`  out  1  arbiter accepts the response.
- `spurious_resp`  out  1  one-cycle pulse when a response arrives in IDLE.

## Operation
- A request *fires* when valid & ready on the same cycle. A response fires under the same rule.
- The FSM has two states: IDLE and BUSY. Registers: `state`, `owner` (IMEM/DMEM), `last_grant`, `lock_valid`, `lock_owner`.

IDLE:
- `mem_req_valid` = `imem_req_valid` | `dmem_req_valid`.
- Grant selection:
  - Only one requester valid: grant that requester.
  - Both valid: grant the requester that is not `last_grant` (round-robin).
- Grant lock: if `lock_valid`, the grant is `lock_owner` regardless of the rule above.
- The mem request fields are muxed from the granted requester. For IMEM: `we`=0, `wdata`=0, `wstrb`=0.
- `<granted>_req_ready` = `mem_req_ready`. The non-granted ready = 0.
- On mem request fire: `owner` ← grant, `last_grant` ← grant, `lock_valid` ← 0, state → BUSY.
- If `mem_req_valid` & !`mem_req_ready`: `lock_valid` ← 1 and `lock_owner` ← grant. The memory side therefore never sees valid drop or the payload change while stalled. Requesters must hold valid and payload until their own ready.
- `mem_resp_ready` = 1 (drains stray responses). A mem response fire here pulses `spurious_resp` and is not forwarded.

BUSY:
- `mem_req_valid` = 0. Both `*_req_ready` = 0.
- `<owner>_resp_valid` = `mem_resp_valid`. The other `resp_valid` = 0.
- `<owner>_resp_data` = `mem_resp_data`.
- `mem_resp_ready` = `<owner>_resp_ready`.
- On mem response fire: state → IDLE.

Reset (mid-operation included):
- state ← IDLE, `lock_valid` ← 0, `last_grant` ← DMEM (IMEM wins the first tie), `owner` ← IMEM.
- An in-flight transaction is abandoned. Its late response is drained as spurious.

## Timing
- All outputs are combinational from the registered state plus inputs. There is no combinational path from `mem_resp_*` to `mem_req_*`.
- Reset values, with inputs low: all `*_valid` = 0, `*_req_ready` = 0, `mem_resp_ready` = 1, `spurious_resp` = 0.
- Request path: zero-cycle pass-through. The arbiter adds no latency to the request.
- The memory must respond no earlier than the cycle after request fire.
- The response fire cycle returns the FSM to IDLE. The next request can fire on the following cycle at the earliest, so minimum spacing is 2 cycles per transaction with single-cycle memory.
- Response back-pressure from the owner stalls the memory response indefinitely. No timeout.

## Structure
- Shared package `mem_arb_pkg`:
  - `owner_t` enum {IMEM, DMEM}.
  - `arb_state_t` enum {IDLE, BUSY}.
- Sub-module `rr_arb2`: a 2-way round-robin grant with lock. Inputs: `req[1:0]`, `last_grant`, `lock_valid`, `lock_owner`. Outputs: `grant`, `any`. Purely combinational.
- Top-level `mem_port_arbiter` holds the FSM, the lock registers and the muxes.

## Test plan
- Fetch only: `imem_req_addr`=0x100, memory ready, response 0x00000013 next cycle → `imem_resp_data`=0x13. `dmem_resp_valid` never asserts.
- Tie after reset: both valid, IMEM addr 0x0, DMEM write 0x200/0xDEADBEEF/wstrb 0xF → IMEM served first, then DMEM. Memory sees `we`=1 with matching data on the second request.
- Stall lock: IMEM valid with `mem_req_ready`=0 for 3 cycles, DMEM raises valid in cycle 1 → `mem_req_addr` stays the IMEM address throughout. IMEM fires when ready rises.
- Response back-pressure: DMEM read, `dmem_resp_ready`=0 for 4 cycles → `mem_resp_ready`=0 for 4 cycles. Both `*_req_ready` stay 0 until the response fires.
- Reset mid-operation: reset asserted in BUSY, then memory responds 2 cycles after reset release → `spurious_resp` pulses once. No `*_resp_valid`. The next IMEM request is accepted.
- Fairness: both requesters continuously valid for 10 transactions → grants alternate IMEM, DMEM, IMEM, … with no requester served twice in a row.
